reg_op_sequencer: RTL and testbench

//  Upstream control stage for register_block. Accepts 16-bit register-op instructions over a valid/ready handshake.

---
 rtl/reg_op_sequencer.sv | 160 ++++++++++++++++
 tb/tb_reg_op_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_op_sequencer.sv
// Register-op sequencer: turns 16-bit LDI/MOV/OUT/NOP instrs into register_block control.
// Optional REG_SEQ_COUNT_EN adds a 16-bit completed-op counter port (op_count).
module reg_op_sequencer #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] dst_reg,
  output logic [ADDR_W-1:0] src_reg,
  output logic              write_enable,
  output logic              read_enable,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef REG_SEQ_COUNT_EN
  output logic [15:0]       op_count,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_EMIT
  } state_t;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_MOV = 2'b10;
  localparam logic [1:0] OP_OUT = 2'b11;

  localparam logic [2:0] LAT_M1 = 3'(RD_LATENCY - 1);

  state_t            r_state;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_dst;
  logic [2:0]        r_lat;

  logic [1:0]        w_op;
  logic [ADDR_W-1:0] w_dst;
  logic [ADDR_W-1:0] w_src;
  logic [DATA_W-1:0] w_imm;
  logic              w_dst_zero;

  assign w_op       = instr[15:14];
  assign w_dst      = ADDR_W'(instr[13:11]);
  assign w_src      = ADDR_W'(instr[10:8]);
  assign w_imm      = DATA_W'(instr[7:0]);
  assign w_dst_zero = (instr[13:11] == 3'd0);

  // Sequencer FSM with all control outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_op         <= OP_NOP;
      r_dst        <= '0;
      r_lat        <= '0;
      instr_ready  <= 1'b1;
      dst_reg      <= '0;
      src_reg      <= '0;
      write_enable <= 1'b0;
      read_enable  <= 1'b0;
      reg_wdata    <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
`ifdef REG_SEQ_COUNT_EN
      op_count     <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_op  <= w_op;
            r_dst <= w_dst;
            unique case (w_op)
              OP_LDI: begin
                if (!w_dst_zero) begin
                  r_state      <= S_WRITE;
                  write_enable <= 1'b1;
                  dst_reg      <= w_dst;
                  reg_wdata    <= w_imm;
                  instr_ready  <= 1'b0;
                  busy         <= 1'b1;
                end
              end
              OP_MOV: begin
                if (!w_dst_zero) begin
                  r_state     <= S_READ;
                  read_enable <= 1'b1;
                  src_reg     <= w_src;
                  r_lat       <= LAT_M1;
                  instr_ready <= 1'b0;
                  busy        <= 1'b1;
                end
              end
              OP_OUT: begin
                r_state     <= S_READ;
                read_enable <= 1'b1;
                src_reg     <= w_src;
                r_lat       <= LAT_M1;
                instr_ready <= 1'b0;
                busy        <= 1'b1;
              end
              OP_NOP: begin
                r_state <= S_IDLE;
              end
            endcase
          end
        end
        S_READ: begin
          if (r_lat == 3'd0) begin
            read_enable <= 1'b0;
            if (r_op == OP_MOV) begin
              r_state      <= S_WRITE;
              write_enable <= 1'b1;
              dst_reg      <= r_dst;
              reg_wdata    <= reg_rdata;
            end else begin
              r_state   <= S_EMIT;
              out_valid <= 1'b1;
              out_data  <= reg_rdata;
            end
          end else begin
            r_lat <= r_lat - 3'd1;
          end
        end
        S_WRITE: begin
          r_state      <= S_IDLE;
          write_enable <= 1'b0;
          instr_ready  <= 1'b1;
          busy         <= 1'b0;
`ifdef REG_SEQ_COUNT_EN
          op_count     <= op_count + 16'd1;
`endif
        end
        S_EMIT: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            out_valid   <= 1'b0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
`ifdef REG_SEQ_COUNT_EN
            op_count    <= op_count + 16'd1;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Scoreboard bench for reg_op_sequencer with a register_block model.
// Directed spec scenarios, mid-op reset, then randomized instrs.
module tb_reg_op_sequencer;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  dst_reg;
  logic [2:0]  src_reg;
  logic        write_enable;
  logic        read_enable;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
`ifdef REG_SEQ_COUNT_EN
  logic [15:0] op_count;
`endif

  reg_op_sequencer #(.DATA_W(8), .ADDR_W(3), .RD_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .dst_reg(dst_reg), .src_reg(src_reg),
    .write_enable(write_enable), .read_enable(read_enable),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef REG_SEQ_COUNT_EN
    .op_count(op_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // register_block model: data valid only in the last cycle of the read window
  logic [7:0] rb [8];
  int rcnt = 0;
  always @(posedge clk) begin
    if (write_enable) rb[dst_reg] <= reg_wdata;
    rcnt <= read_enable ? rcnt + 1 : 0;
  end
  assign reg_rdata = (read_enable && rcnt == L - 1) ? rb[src_reg] : ~rb[src_reg];

  // reference model state
  typedef struct packed {
    logic       is_out;
    logic [2:0] dst;
    logic [7:0] data;
  } exp_t;
  exp_t q[$];
  logic [7:0] mregs [8];
  int mcount = 0;

  // out_ready driver
  int or_hold = 0;
  bit or_rand = 0;
  always @(posedge clk) begin
    #1;
    if (or_hold > 0 && out_valid) begin
      out_ready = 1'b0;
      or_hold--;
    end else if (or_rand) begin
      out_ready = 1'($urandom % 2);
    end else begin
      out_ready = 1'b1;
    end
  end

  // monitor: pops expectations when the DUT writes or emits
  bit prev_ov = 0, prev_or = 0;
  logic [7:0] prev_od = 0;
  int ov_run = 0, last_ov_len = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (write_enable && read_enable) chk("we_re_overlap", 1, 0);
      if (prev_ov && !prev_or) begin
        chk("ov_hold", {31'd0, out_valid}, 1);
        chk("od_stable", {24'd0, out_data}, {24'd0, prev_od});
      end
      if (write_enable) begin
        if (q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = q.pop_front();
          chk("write_kind", {31'd0, e.is_out}, 0);
          chk("write_dst", {29'd0, dst_reg}, {29'd0, e.dst});
          chk("write_data", {24'd0, reg_wdata}, {24'd0, e.data});
        end
      end
      if (out_valid) begin
        ov_run++;
        if (out_ready) begin
          last_ov_len = ov_run;
          ov_run = 0;
          if (q.size() == 0) chk("unexpected_out", 1, 0);
          else begin
            e = q.pop_front();
            chk("out_kind", {31'd0, e.is_out}, 1);
            chk("out_data", {24'd0, out_data}, {24'd0, e.data});
          end
        end
      end
    end
    prev_ov = out_valid;
    prev_or = out_ready;
    prev_od = out_data;
  end

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk("ready_timeout", 1, 0);
  endtask

  // issue one instr, apply reference model, check accept->IDLE latency
  task automatic issue(logic [1:0] op, logic [2:0] d, logic [2:0] s,
                       logic [7:0] imm, int exact_lat);
    int exp_lat, n;
    exp_t e;
    wait_ready();
    instr = {op, d, s, imm};
    instr_valid = 1'b1;
    exp_lat = 1;
    case (op)
      2'd1: if (d != 0) begin
        e = '{is_out: 0, dst: d, data: imm};
        q.push_back(e);
        mregs[d] = imm;
        exp_lat = 2;
        mcount++;
      end
      2'd2: if (d != 0) begin
        e = '{is_out: 0, dst: d, data: mregs[s]};
        q.push_back(e);
        mregs[d] = mregs[s];
        exp_lat = L + 2;
        mcount++;
      end
      2'd3: begin
        e = '{is_out: 1, dst: 0, data: mregs[s]};
        q.push_back(e);
        exp_lat = -1;
        mcount++;
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);
    @(negedge clk);
    n = 1;
    while (!instr_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exact_lat > 0) chk("lat_exact", n, exact_lat);
    else if (exp_lat > 0) chk("lat", n, exp_lat);
    else chk("out_lat_min", {31'd0, n >= L + 2}, 1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", {31'd0, instr_ready}, 1);
    chk("rst_we", {31'd0, write_enable}, 0);
    chk("rst_re", {31'd0, read_enable}, 0);
    chk("rst_ov", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (rb[i]) rb[i] = 8'h00;
    foreach (mregs[i]) mregs[i] = 8'h00;
    instr = 16'h0;
    instr_valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
`ifdef REG_SEQ_COUNT_EN
    chk("rst_count", {16'd0, op_count}, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    issue(2'd1, 3'd1, 3'd0, 8'h55, 2);
    issue(2'd1, 3'd2, 3'd0, 8'hAA, 2);
    issue(2'd2, 3'd5, 3'd1, 8'h00, L + 2);
    or_hold = 4;
    issue(2'd3, 3'd0, 3'd5, 8'h00, L + 6);
    chk("out_hold_len", last_ov_len, 5);
    issue(2'd1, 3'd0, 3'd0, 8'hFF, 1);
    issue(2'd0, 3'd3, 3'd4, 8'h12, 1);
    issue(2'd2, 3'd3, 3'd3, 8'h00, L + 2);
    chk("r1", {24'd0, rb[1]}, 32'h55);
    chk("r2", {24'd0, rb[2]}, 32'hAA);
    chk("r5", {24'd0, rb[5]}, 32'h55);

    wait_ready();
    instr = {2'd2, 3'd5, 3'd2, 8'h00};
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    chk("mid_read", {31'd0, read_enable}, 1);
    rst = 1'b0;
    #1;
    check_reset_outputs();
    mcount = 0;
`ifdef REG_SEQ_COUNT_EN
    chk("abort_count", {16'd0, op_count}, 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (L + 4) @(negedge clk);
    chk("r5_after_abort", {24'd0, rb[5]}, 32'h55);

    or_rand = 1;
    for (int i = 0; i < 200; i++) begin
      issue(2'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), 0);
    end
    or_rand = 0;
    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    for (int r = 0; r < 8; r++) begin
      chk($sformatf("final_r%0d", r), {24'd0, rb[r]}, {24'd0, mregs[r]});
    end
`ifdef REG_SEQ_COUNT_EN
    chk("final_count", {16'd0, op_count}, mcount);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
